// File: rtl/dma_line_engine_if.sv
// dma_line_engine_if
//   Bundles the command/status signals, the SDRAM word port and the on-chip
//   line-memory port of the DMA line engine.
//   master : the engine (drives requests, addresses, write data, status)
//   slave  : the surroundings (command source, SDRAM controller, memories)
//   Command : start, rw, sdram_addr, mem_bank, mem_addr, line_count
//   Status  : busy, done, err
//   SDRAM   : sdram_rd_en, sdram_wr_en, sdram_addr_out, sdram_wdata,
//             sdram_rdata, sdram_ready
//   Memory  : mem_rd_en, mem_wr_en, mem_sel, mem_addr_out, mem_wdata,
//             mem_rdata, mem_ready (one ready bit per bank)
interface dma_line_engine_if #(
  parameter int SD_W       = 64,
  parameter int LINE_WORDS = 4,
  parameter int SD_AW      = 8,
  parameter int MEM_AW     = 6,
  parameter int NUM_BANKS  = 2,
  parameter int LEN_W      = 8
);
  localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int LW = SD_W * LINE_WORDS;

  logic                 start;
  logic                 rw;
  logic [SD_AW-1:0]     sdram_addr;
  logic [BW-1:0]        mem_bank;
  logic [MEM_AW-1:0]    mem_addr;
  logic [LEN_W-1:0]     line_count;
  logic                 busy;
  logic                 done;
  logic                 err;

  logic                 sdram_rd_en;
  logic                 sdram_wr_en;
  logic [SD_AW-1:0]     sdram_addr_out;
  logic [SD_W-1:0]      sdram_wdata;
  logic [SD_W-1:0]      sdram_rdata;
  logic                 sdram_ready;

  logic                 mem_rd_en;
  logic                 mem_wr_en;
  logic [BW-1:0]        mem_sel;
  logic [MEM_AW-1:0]    mem_addr_out;
  logic [LW-1:0]        mem_wdata;
  logic [LW-1:0]        mem_rdata;
  logic [NUM_BANKS-1:0] mem_ready;

  modport master (
    input  start, rw, sdram_addr, mem_bank, mem_addr, line_count,
    output busy, done, err,
    output sdram_rd_en, sdram_wr_en, sdram_addr_out, sdram_wdata,
    input  sdram_rdata, sdram_ready,
    output mem_rd_en, mem_wr_en, mem_sel, mem_addr_out, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    output start, rw, sdram_addr, mem_bank, mem_addr, line_count,
    input  busy, done, err,
    input  sdram_rd_en, sdram_wr_en, sdram_addr_out, sdram_wdata,
    output sdram_rdata, sdram_ready,
    input  mem_rd_en, mem_wr_en, mem_sel, mem_addr_out, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/dma_line_engine.sv
// dma_line_engine
//   Moves whole lines between the SDRAM word port and one of NUM_BANKS
//   on-chip line memories, in either direction. A line is LINE_WORDS SDRAM
//   words; word k of a line occupies bits [k*SD_W +: SD_W].
//   Ports:
//     clk_h : clock
//     rst_n : asynchronous active-low reset (aborts any command, no done)
//     bus   : dma_line_engine_if.master (command, status, SDRAM, memory)
//   All requests, addresses and write data come straight from registers, so
//   they stay put while the addressed side holds ready low.
module dma_line_engine #(
  parameter int SD_W       = 64,
  parameter int LINE_WORDS = 4,
  parameter int SD_AW      = 8,
  parameter int MEM_AW     = 6,
  parameter int NUM_BANKS  = 2,
  parameter int LEN_W      = 8
) (
  input logic               clk_h,
  input logic               rst_n,
  dma_line_engine_if.master bus
);
  localparam int BW  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int KW  = $clog2(LINE_WORDS);
  localparam int NB2 = 1 << BW;
  localparam logic [KW-1:0] K_LAST = KW'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE, S2M_RD, S2M_WR, M2S_RD, M2S_WAIT, M2S_WR, FIN
  } state_t;

  state_t                        state, state_d;
  logic [KW-1:0]                 k;
  logic [SD_AW-1:0]              sd_addr_q;
  logic [MEM_AW-1:0]             mem_addr_q;
  logic [BW-1:0]                 bank_q;
  logic [LEN_W-1:0]              lines_left;
  logic [LINE_WORDS-1:0][SD_W-1:0] line_buf;
  logic sd_rd_q, sd_wr_q, m_rd_q, m_wr_q, busy_q, done_q, err_q;

  logic [NB2-1:0] rdy_ext;
  logic           mem_acc, sd_acc, bad_bank, last_word, last_line;

  // Pad the ready vector to a power of two so any bank_q value indexes safely.
  assign rdy_ext   = NB2'(bus.mem_ready);
  assign mem_acc   = rdy_ext[bank_q];
  assign sd_acc    = bus.sdram_ready;
  assign bad_bank  = (int'(bus.mem_bank) >= NUM_BANKS);
  assign last_word = (k == K_LAST);
  assign last_line = (lines_left == LEN_W'(1));

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if ((bus.line_count == '0) || bad_bank) state_d = FIN;
          else if (bus.rw)                        state_d = M2S_RD;
          else                                    state_d = S2M_RD;
        end
      end
      S2M_RD:   if (sd_acc && last_word) state_d = S2M_WR;
      S2M_WR:   if (mem_acc) state_d = last_line ? FIN : S2M_RD;
      M2S_RD:   if (mem_acc) state_d = M2S_WAIT;
      M2S_WAIT: state_d = M2S_WR;
      M2S_WR:   if (sd_acc && last_word) state_d = last_line ? FIN : M2S_RD;
      FIN:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_h or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      k          <= '0;
      sd_addr_q  <= '0;
      mem_addr_q <= '0;
      bank_q     <= '0;
      lines_left <= '0;
      line_buf   <= '0;
      sd_rd_q    <= 1'b0;
      sd_wr_q    <= 1'b0;
      m_rd_q     <= 1'b0;
      m_wr_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state   <= state_d;
      sd_rd_q <= (state_d == S2M_RD);
      sd_wr_q <= (state_d == M2S_WR);
      m_rd_q  <= (state_d == M2S_RD);
      m_wr_q  <= (state_d == S2M_WR);
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == FIN);
      // Only an invalid bank goes to FIN with err; valid commands never flag.
      err_q   <= (state == IDLE) && bus.start && bad_bank;

      case (state)
        IDLE: begin
          if (bus.start) begin
            sd_addr_q  <= bus.sdram_addr;
            mem_addr_q <= bus.mem_addr;
            bank_q     <= bus.mem_bank;
            lines_left <= bus.line_count;
            k          <= '0;
          end
        end
        S2M_RD: begin
          if (sd_acc) begin
            line_buf[k] <= bus.sdram_rdata;
            k           <= k + 1'b1;
            sd_addr_q   <= sd_addr_q + 1'b1;
          end
        end
        S2M_WR: begin
          if (mem_acc) begin
            mem_addr_q <= mem_addr_q + 1'b1;
            lines_left <= lines_left - 1'b1;
          end
        end
        M2S_WAIT: line_buf <= bus.mem_rdata;
        M2S_WR: begin
          if (sd_acc) begin
            k         <= k + 1'b1;
            sd_addr_q <= sd_addr_q + 1'b1;
            if (last_word) begin
              mem_addr_q <= mem_addr_q + 1'b1;
              lines_left <= lines_left - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.err            = err_q;
  assign bus.sdram_rd_en    = sd_rd_q;
  assign bus.sdram_wr_en    = sd_wr_q;
  assign bus.sdram_addr_out = sd_addr_q;
  assign bus.sdram_wdata    = line_buf[k];
  assign bus.mem_rd_en      = m_rd_q;
  assign bus.mem_wr_en      = m_wr_q;
  assign bus.mem_sel        = bank_q;
  assign bus.mem_addr_out   = mem_addr_q;
  assign bus.mem_wdata      = line_buf;
endmodule

// File: tb/tb_dma_line_engine.sv
// tb_dma_line_engine
//   Scoreboard bench for dma_line_engine with three banks (so a 2-bit bank
//   field can name an invalid bank). SDRAM returns word = address; the
//   memory model holds lines per bank and answers reads one cycle later.
module tb_dma_line_engine;
  localparam int SD_W = 64;
  localparam int LWD  = 4;
  localparam int NB   = 3;
  localparam int LW   = SD_W * LWD;

  logic clk_h;
  logic rst_n;

  dma_line_engine_if #(.NUM_BANKS(NB)) bus ();

  dma_line_engine #(.NUM_BANKS(NB)) dut (
    .clk_h (clk_h),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk_h = 1'b0;
  always #5 clk_h = ~clk_h;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard queues
  logic [7:0]   q_sd_rd[$];   // sdram read address
  logic [71:0]  q_sd_wr[$];   // {addr, data}
  logic [7:0]   q_mem_rd[$];  // {bank, addr}
  logic [263:0] q_mem_wr[$];  // {bank, addr, line}

  logic [LW-1:0] mem_model [NB][64];

  // Environment behaviour controls
  bit       sd_toggle = 0;
  bit       tog_phase = 0;
  int       mem_stall_left = 0;
  int       done_cnt = 0;

  logic [511:0] held;
  bit           held_v = 0;
  bit           mrd_pend = 0;
  logic [1:0]   pend_bank;
  logic [5:0]   pend_addr;
  logic         sd_rdy;
  logic [NB-1:0] mrdy;

  function automatic logic [511:0] snap();
    return 512'({bus.busy, bus.done, bus.err,
                 bus.sdram_rd_en, bus.sdram_wr_en, bus.mem_rd_en, bus.mem_wr_en,
                 bus.sdram_addr_out, bus.sdram_wdata, bus.mem_sel,
                 bus.mem_addr_out, bus.mem_wdata});
  endfunction

  task automatic push_s2m(input logic [7:0] sa, input logic [1:0] bk,
                          input logic [5:0] ma, input int cnt);
    logic [LW-1:0] line;
    logic [7:0] a;
    for (int i = 0; i < cnt; i++) begin
      for (int j = 0; j < LWD; j++) begin
        a = 8'(int'(sa) + i * LWD + j);
        q_sd_rd.push_back(a);
        line[j*SD_W +: SD_W] = 64'(a);
      end
      q_mem_wr.push_back({bk, 6'(int'(ma) + i), line});
    end
  endtask

  task automatic push_m2s(input logic [7:0] sa, input logic [1:0] bk,
                          input logic [5:0] ma, input int cnt, input bit fixed);
    logic [LW-1:0] line;
    logic [5:0] m;
    for (int i = 0; i < cnt; i++) begin
      m = 6'(int'(ma) + i);
      for (int j = 0; j < LWD; j++)
        line[j*SD_W +: SD_W] = fixed ? 64'(10 + j) : {$urandom(), $urandom()};
      mem_model[bk][m] = line;
      q_mem_rd.push_back({bk, m});
      for (int j = 0; j < LWD; j++)
        q_sd_wr.push_back({8'(int'(sa) + i * LWD + j), line[j*SD_W +: SD_W]});
    end
  endtask

  // Environment: decides ready for the coming edge, supplies read data and
  // checks every accepted transfer against the scoreboard.
  initial begin
    forever begin
      @(negedge clk_h);
      if (!rst_n) begin
        held_v   = 0;
        mrd_pend = 0;
      end else begin
        if (bus.done) done_cnt++;
        check("onehot_en", 512'($countones({bus.sdram_rd_en, bus.sdram_wr_en,
                                            bus.mem_rd_en, bus.mem_wr_en}) > 1), 512'(0));
        if (mrd_pend) begin
          bus.mem_rdata = mem_model[pend_bank][pend_addr];
          mrd_pend = 0;
        end else begin
          bus.mem_rdata = {8{32'hDEAD_BEEF}};
        end
        bus.sdram_rdata = 64'(bus.sdram_addr_out);

        sd_rdy = 1'b1;
        if (sd_toggle && (bus.sdram_rd_en || bus.sdram_wr_en)) begin
          sd_rdy    = tog_phase;
          tog_phase = ~tog_phase;
        end
        mrdy = '1;
        if (mem_stall_left > 0 && bus.mem_wr_en) begin
          mrdy[bus.mem_sel] = 1'b0;
          mem_stall_left--;
        end
        bus.sdram_ready = sd_rdy;
        bus.mem_ready   = mrdy;

        if (held_v) check("stall_hold", snap(), held);
        held_v = 0;
        if (((bus.sdram_rd_en || bus.sdram_wr_en) && !sd_rdy) ||
            ((bus.mem_rd_en || bus.mem_wr_en) && !mrdy[bus.mem_sel])) begin
          held   = snap();
          held_v = 1;
        end

        if (bus.sdram_rd_en && sd_rdy) begin
          if (q_sd_rd.size() == 0) check("sd_rd_unexpected", 1, 0);
          else check("sd_rd_addr", 512'(bus.sdram_addr_out), 512'(q_sd_rd.pop_front()));
        end
        if (bus.sdram_wr_en && sd_rdy) begin
          if (q_sd_wr.size() == 0) check("sd_wr_unexpected", 1, 0);
          else check("sd_wr", 512'({bus.sdram_addr_out, bus.sdram_wdata}),
                     512'(q_sd_wr.pop_front()));
        end
        if (bus.mem_rd_en && mrdy[bus.mem_sel]) begin
          if (q_mem_rd.size() == 0) check("mem_rd_unexpected", 1, 0);
          else check("mem_rd", 512'({bus.mem_sel, bus.mem_addr_out}),
                     512'(q_mem_rd.pop_front()));
          mrd_pend  = 1;
          pend_bank = bus.mem_sel;
          pend_addr = bus.mem_addr_out;
        end
        if (bus.mem_wr_en && mrdy[bus.mem_sel]) begin
          if (q_mem_wr.size() == 0) check("mem_wr_unexpected", 1, 0);
          else check("mem_wr", 512'({bus.mem_sel, bus.mem_addr_out, bus.mem_wdata}),
                     512'(q_mem_wr.pop_front()));
          mem_model[bus.mem_sel][bus.mem_addr_out] = bus.mem_wdata;
        end
      end
    end
  end

  task automatic drive_cmd(input bit rw_i, input logic [7:0] sa, input logic [1:0] bk,
                           input logic [5:0] ma, input logic [7:0] cnt);
    @(negedge clk_h);
    bus.rw         = rw_i;
    bus.sdram_addr = sa;
    bus.mem_bank   = bk;
    bus.mem_addr   = ma;
    bus.line_count = cnt;
    bus.start      = 1'b1;
    @(negedge clk_h);
    bus.start      = 1'b0;
  endtask

  task automatic run_cmd(input string tag, input bit rw_i, input logic [7:0] sa,
                         input logic [1:0] bk, input logic [5:0] ma, input logic [7:0] cnt,
                         input int exp_cyc, input bit exp_err, input bit poke);
    int cyc;
    bit seen;
    drive_cmd(rw_i, sa, bk, ma, cnt);
    cyc  = 1;
    seen = 0;
    check({tag, "_busy"}, 512'(bus.busy), 512'(1));
    while (!seen && cyc < 300) begin
      if (bus.done) seen = 1;
      else begin
        bus.start = (poke && cyc == 3);
        @(negedge clk_h);
        cyc++;
      end
    end
    bus.start = 1'b0;
    check({tag, "_timeout"}, 512'(seen), 512'(1));
    check({tag, "_cycles"}, 512'(cyc), 512'(exp_cyc));
    check({tag, "_err"}, 512'(bus.err), 512'(exp_err));
    @(negedge clk_h);
    check({tag, "_done_pulse"}, 512'({bus.done, bus.err, bus.busy}), 512'(0));
    check({tag, "_sb_empty"},
          512'(q_sd_rd.size() + q_sd_wr.size() + q_mem_rd.size() + q_mem_wr.size()), 512'(0));
  endtask

  initial begin
    int d0;
    rst_n           = 1'b0;
    bus.start       = 1'b0;
    bus.rw          = 1'b0;
    bus.sdram_addr  = '0;
    bus.mem_bank    = '0;
    bus.mem_addr    = '0;
    bus.line_count  = '0;
    bus.sdram_rdata = '0;
    bus.sdram_ready = 1'b1;
    bus.mem_rdata   = '0;
    bus.mem_ready   = '1;
    repeat (3) @(negedge clk_h);
    check("rst_outputs", snap(), 512'(0));
    check("rst_busy", 512'(bus.busy), 512'(0));
    rst_n = 1'b1;

    push_s2m(8'h10, 2'd1, 6'd5, 2);
    run_cmd("s2m_basic", 1'b0, 8'h10, 2'd1, 6'd5, 8'd2, 11, 1'b0, 1'b0);

    sd_toggle = 1; tog_phase = 0;
    push_m2s(8'h40, 2'd1, 6'd3, 1, 1'b1);
    run_cmd("m2s_toggle", 1'b1, 8'h40, 2'd1, 6'd3, 8'd1, 11, 1'b0, 1'b0);
    sd_toggle = 0;

    run_cmd("zero_len", 1'b0, 8'h00, 2'd0, 6'd0, 8'd0, 1, 1'b0, 1'b0);
    run_cmd("bad_bank", 1'b1, 8'h00, 2'd3, 6'd0, 8'd1, 1, 1'b1, 1'b0);

    push_s2m(8'hFE, 2'd0, 6'd63, 2);
    run_cmd("s2m_wrap", 1'b0, 8'hFE, 2'd0, 6'd63, 8'd2, 11, 1'b0, 1'b0);
    push_m2s(8'hFE, 2'd2, 6'd63, 1, 1'b0);
    run_cmd("m2s_wrap", 1'b1, 8'hFE, 2'd2, 6'd63, 8'd1, 7, 1'b0, 1'b0);

    mem_stall_left = 5;
    push_s2m(8'h80, 2'd0, 6'd10, 1);
    run_cmd("mem_stall", 1'b0, 8'h80, 2'd0, 6'd10, 8'd1, 11, 1'b0, 1'b1);

    // Abort mid-line with an asynchronous reset between clock edges.
    push_s2m(8'h30, 2'd1, 6'd0, 2);
    drive_cmd(1'b0, 8'h30, 2'd1, 6'd0, 8'd2);
    repeat (2) @(negedge clk_h);
    d0 = done_cnt;
    #2 rst_n = 1'b0;
    #1 check("abort_outputs", snap(), 512'(0));
    q_sd_rd.delete();
    q_sd_wr.delete();
    q_mem_rd.delete();
    q_mem_wr.delete();
    @(negedge clk_h);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_h);
    check("abort_no_done", 512'(done_cnt - d0), 512'(0));
    check("abort_idle", 512'(bus.busy), 512'(0));

    push_m2s(8'h20, 2'd0, 6'd20, 2, 1'b0);
    run_cmd("after_abort", 1'b1, 8'h20, 2'd0, 6'd20, 8'd2, 13, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
